// File: rtl/iterative_divider.sv
// Radix-2 restoring divide/remainder unit (RV32/RV64 M-extension DIV, DIVU, REM, REMU).
// Latency: done WIDTH+1 cycles after the start cycle; divide-by-zero and signed overflow finish the cycle after start.
// Backpressure: stall holds upstream while starting or running; start is ignored while busy; flush aborts the operation.
// Ports: clk, reset (sync, active-high), start/op/a/b request, flush abort,
//        stall/busy status, done pulse with result (quotient or remainder per op).
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;     // holds the dividend magnitude, shifts into the quotient
  logic [WIDTH-1:0] rem_q;     // partial remainder
  logic [WIDTH-1:0] div_q;     // divisor magnitude
  logic             is_rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [WIDTH-1:0] pend_q;    // final value staged for the DONE cycle
  logic [WIDTH-1:0] result_q;

  // ---------------- operand decode ----------------
  logic             accept;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic             special;
  logic [WIDTH-1:0] special_res;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  // Two's-complement negation of the most negative value yields 2^(WIDTH-1),
  // which is its correct magnitude when read as unsigned.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign div_zero  = (b == '0);
  assign sgn_ovf   = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
  assign special   = div_zero | sgn_ovf;
  // Divide by zero: quotient all ones, remainder = dividend.
  // Overflow: quotient = dividend, remainder 0.
  assign special_res = div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

  // ---------------- restoring step ----------------
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] fin_val;

  assign rem_shift = {rem_q, quo_q[WIDTH-1]};
  assign diff      = rem_shift - {1'b0, div_q};
  assign ge        = ~diff[WIDTH];
  assign rem_step  = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], ge};
  assign fin_val   = is_rem_q ? (neg_rem_q ? -rem_step : rem_step)
                              : (neg_quo_q ? -quo_step : quo_step);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = special ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)                 state_d = S_IDLE;
        else if (cnt_q == CNT_ONE) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall  = accept || (state_q == S_RUN);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE) && !flush;
    // The staged value is shown during the done cycle; the register keeps it afterwards.
    result = done ? pend_q : result_q;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      pend_q    <= '0;
      result_q  <= '0;
    end else begin
      if (accept) begin
        quo_q     <= a_mag;
        rem_q     <= '0;
        div_q     <= b_mag;
        cnt_q     <= special ? '0 : CNT_INIT;
        is_rem_q  <= op[1];
        neg_quo_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        pend_q    <= special_res;
      end else if (state_q == S_RUN) begin
        if (flush) begin
          cnt_q <= '0;
        end else begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) pend_q <= fin_val;
        end
      end else if (state_q == S_DONE && !flush) begin
        result_q <= pend_q;
      end
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
module tb_iterative_divider;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic         clk = 1'b0;
  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         stall, busy, done;
  logic [W-1:0] result;

  always #5 clk = ~clk;

  iterative_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           stall_cnt = 0;
  logic [W-1:0] last_result = '0;
  logic [W-1:0] last_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RISC-V semantics from plain integer arithmetic.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    if (y == 0) return o[1] ? x : {W{1'b1}};
    if (!o[0]) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return o[1] ? W'(sx % sy) : W'(sx / sy);
    end
    return o[1] ? (x % y) : (x / y);
  endfunction

  task automatic check32(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pop on every done pulse, plus stall cycle counting.
  initial begin
    exp_t e;
    logic done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stall === 1'b1) stall_cnt++;
      if (done === 1'b1) begin
        check_int("done_width", int'(done_prev), 0);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done high with result %h, no operation expected (cycle %0d)", result, cyc);
        end else begin
          e = sb_q.pop_front();
          check32("result", result, e.res);
          check_int("done_cycle", cyc, e.cyc);
        end
      end
      done_prev = (done === 1'b1);
    end
  end

  // Caller is at posedge+#1 of the start cycle; returns at posedge+#1 of the next cycle.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
    exp_t e;
    bit   spec;
    op = o; a = x; b = y; start = 1'b1;
    last_exp = model(o, x, y);
    spec = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    if (push) begin
      e.res = last_exp;
      e.cyc = cyc + (spec ? 1 : W + 1);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100 && done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_timeout: done not seen within 100 cycles (cycle %0d)", name, cyc);
    end
  endtask

  // Full operation; ends in the idle cycle right after done so the next start is back-to-back.
  task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start_op(o, x, y, 1'b1);
    wait_done(name);
    last_result = last_exp;
    @(posedge clk); #1;
    check32({name, "_hold"}, result, last_result);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    reset = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_stall", int'(stall), 0);
    check32("rst_result", result, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    s0 = stall_cnt;
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7);
    check_int("stall_cycles", stall_cnt - s0, W + 1);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7);
    run_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2);
    run_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2);
    run_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE);
    run_op("divu_by0",   OP_DIVU, 32'h1234_5678, 32'd0);
    run_op("remu_by0",   OP_REMU, 32'h1234_5678, 32'd0);
    run_op("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run_op("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);

    // Flush mid-run: no done, result keeps the previous value.
    start_op(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_int("flush_busy", int'(busy), 0);
    check_int("flush_stall", int'(stall), 0);
    check32("flush_result", result, last_result);
    repeat (3) begin @(posedge clk); #1; end
    check_int("flush_idle", int'(busy), 0);
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3);

    // Flush during the done cycle of a divide-by-zero: pulse masked, result not written.
    start_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_int("flushdone_busy", int'(busy), 0);
    check32("flushdone_result", result, last_result);
    @(posedge clk); #1;

    // Reset mid-run.
    start_op(OP_DIV, 32'hDEAD_BEEF, 32'd7, 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_int("midrst_busy", int'(busy), 0);
    check_int("midrst_done", int'(done), 0);
    check32("midrst_result", result, '0);
    last_result = '0;
    @(posedge clk); #1;

    // Start pulse while busy is ignored.
    start_op(OP_DIVU, 32'd1000, 32'd3, 1'b1);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; op = OP_REMU; a = 32'd77; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("busy_start");
    last_result = last_exp;
    @(posedge clk); #1;
    check32("busy_start_hold", result, last_result);

    // Randomized back-to-back and gapped operations.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [W-1:0] x, y;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = '0;
        1:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2:       y = 32'($urandom_range(1, 20));
        3:       y = -32'($urandom_range(1, 20));
        default: y = $urandom;
      endcase
      run_op("rand", o, x, y);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) begin @(posedge clk); #1; end
    check_int("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
